butterfly_ctrl: RTL and testbench

BUTTERFLY_CTRL -- requirements
Module: butterfly_ctrl

---
 rtl/butterfly_ctrl.sv | 108 ++++++++++
 tb/tb_butterfly_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_ctrl.sv
// Row-flow controller for a 4-stage (32/16/8/4-point) butterfly pipeline.
// Optional sticky protocol-error flag is built when BUTTERFLY_CTRL_ERR_EN is defined.
module butterfly_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] size,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       out_ready,
   output logic       en_32,
   output logic       en_16,
   output logic       en_8,
   output logic       en_4,
   output logic       out_valid,
   output logic       out_last,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t     state;
   state_t     state_nx;
   logic [1:0] size_q;
   logic [4:0] cnt;
   logic [4:0] last_idx;
   logic [3:0] v;
   logic [3:0] l;
   logic       adv;
   logic       accept;
   logic       is_last;

   always_comb begin
      case (size_q)
         2'd0:    last_idx = 5'd3;
         2'd1:    last_idx = 5'd7;
         2'd2:    last_idx = 5'd15;
         default: last_idx = 5'd31;
      endcase
   end

   // Valid/ready: a row moves across an interface in any cycle where both
   // valid and ready are high; the whole pipeline advances as one unit.
   assign adv      = !v[3] || out_ready;
   assign in_ready = (state == RUN) && adv;
   assign accept   = in_valid && in_ready;
   assign is_last  = (cnt == last_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (accept && is_last) state_nx = FLUSH;
         FLUSH:   if (v == 4'b0000) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         size_q <= 2'd0;
         cnt    <= 5'd0;
      end else if (state == IDLE && start) begin
         size_q <= size;
         cnt    <= 5'd0;
      end else if (accept) begin
         cnt <= cnt + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= 4'b0000;
         l <= 4'b0000;
      end else if (adv) begin
         v <= {v[2:0], accept};
         l <= {l[2:0], accept && is_last};
      end
   end

   assign en_32     = v[0] && (size_q == 2'd3);
   assign en_16     = v[1] && size_q[1];
   assign en_8      = v[2] && (size_q != 2'd0);
   assign en_4      = v[3];
   assign out_valid = v[3];
   assign out_last  = v[3] && l[3];
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

`ifdef BUTTERFLY_CTRL_ERR_EN
   logic err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       err_q <= 1'b0;
      else if (start && state != IDLE) err_q <= 1'b1;
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_butterfly_ctrl.sv
// Self-checking bench for butterfly_ctrl: row-index pipeline model compared every cycle,
// plus literal count checks for the directed scenarios.
module tb_butterfly_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] size;
   logic       in_valid;
   logic       in_ready;
   logic       out_ready;
   logic       en_32, en_16, en_8, en_4;
   logic       out_valid, out_last, busy, done, err;

`ifdef BUTTERFLY_CTRL_ERR_EN
   localparam bit ERR_ON = 1'b1;
`else
   localparam bit ERR_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   butterfly_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .size(size),
      .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
      .en_32(en_32), .en_16(en_16), .en_8(en_8), .en_4(en_4),
      .out_valid(out_valid), .out_last(out_last), .busy(busy),
      .done(done), .err(err)
   );

   int total = 0;
   int bad   = 0;

   // model: phase 0 idle, 1 run, 2 flush, 3 done; pipe holds row index or -1
   int m_mode, m_sz, m_cnt;
   int m_pipe[4];
   bit m_err;

   int c_inr, c_acc, c_e32, c_e16, c_e8, c_e4, c_last, c_xfer, c_done, c_stall_inr;

   task automatic chk(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_sz = 0; m_cnt = 0; m_err = 1'b0;
      for (int i = 0; i < 4; i++) m_pipe[i] = -1;
   endtask

   task automatic clr_counts();
      c_inr = 0; c_acc = 0; c_e32 = 0; c_e16 = 0; c_e8 = 0; c_e4 = 0;
      c_last = 0; c_xfer = 0; c_done = 0; c_stall_inr = 0;
   endtask

   // Called at posedge+1 with inputs already driven; compares at the negedge,
   // then advances the model across the next rising edge.
   task automatic cycle();
      int  n;
      bit  v3, adv, e_inr, acc, empty;
      #4;
      n     = 4 << m_sz;
      v3    = (m_pipe[3] >= 0);
      adv   = !v3 || out_ready;
      e_inr = (m_mode == 1) && adv;
      acc   = e_inr && in_valid;
      chk("in_ready",  in_ready,  e_inr);
      chk("en_32",     en_32,     m_pipe[0] >= 0 && m_sz == 3);
      chk("en_16",     en_16,     m_pipe[1] >= 0 && m_sz >= 2);
      chk("en_8",      en_8,      m_pipe[2] >= 0 && m_sz >= 1);
      chk("en_4",      en_4,      v3);
      chk("out_valid", out_valid, v3);
      chk("out_last",  out_last,  v3 && m_pipe[3] == n - 1);
      chk("busy",      busy,      m_mode != 0);
      chk("done",      done,      m_mode == 3);
      chk("err",       err,       m_err);
      c_inr  += int'(in_ready);
      c_acc  += int'(in_ready && in_valid);
      c_e32  += int'(en_32);
      c_e16  += int'(en_16);
      c_e8   += int'(en_8);
      c_e4   += int'(en_4);
      c_last += int'(out_last);
      c_xfer += int'(out_valid && out_ready);
      c_done += int'(done);
      if (!out_ready) c_stall_inr += int'(in_ready);
      @(posedge clk);
      empty = (m_pipe[0] < 0) && (m_pipe[1] < 0) && (m_pipe[2] < 0) && (m_pipe[3] < 0);
      if (ERR_ON && start && m_mode != 0) m_err = 1'b1;
      if (adv) begin
         m_pipe[3] = m_pipe[2];
         m_pipe[2] = m_pipe[1];
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = acc ? m_cnt : -1;
      end
      case (m_mode)
         0: if (start) begin m_mode = 1; m_sz = int'(size); m_cnt = 0; end
         1: if (acc) begin
               if (m_cnt == n - 1) m_mode = 2;
               m_cnt++;
            end
         2: if (empty) m_mode = 3;
         default: m_mode = 0;
      endcase
      #1;
   endtask

   // One block: start pulse, then flow until the model returns to idle.
   task automatic run_block(input int sz, input int iv_pct, input int or_pct,
                            input int stall_at, input int restart_row);
      int k;
      clr_counts();
      start = 1'b1; size = 2'(sz); in_valid = 1'b0; out_ready = 1'b1;
      cycle();
      start = 1'b0;
      size  = 2'($urandom_range(0, 3));
      k = 0;
      while (m_mode != 0 && k < 400) begin
         in_valid  = ($urandom_range(0, 99) < iv_pct);
         out_ready = ($urandom_range(0, 99) < or_pct);
         if (stall_at >= 0 && k >= stall_at && k < stall_at + 3) out_ready = 1'b0;
         start = (restart_row >= 0 && m_mode == 1 && m_cnt == restart_row);
         cycle();
         k++;
      end
      start = 1'b0; in_valid = 1'b0;
      if (k >= 400) begin
         total++; bad++;
         $display("FAIL block_timeout size=%0d: got %0d cycles want <400", sz, k);
      end
   endtask

   initial begin
      int k;
      rst_n = 1'b0; start = 1'b0; size = 2'd0; in_valid = 1'b0; out_ready = 1'b0;
      model_reset();
      clr_counts();
      #1;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_busy",     busy,     1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle();
      cycle();

      // 4x4 continuous flow
      run_block(0, 100, 100, -1, -1);
      chk_int("s0_in_ready_cycles", c_inr, 4);
      chk_int("s0_en_4_cycles", c_e4, 4);
      chk_int("s0_out_last", c_last, 1);
      chk_int("s0_done", c_done, 1);
      cycle();

      // 32x32 continuous flow
      run_block(3, 100, 100, -1, -1);
      chk_int("s3_accepts", c_acc, 32);
      chk_int("s3_en_32", c_e32, 32);
      chk_int("s3_en_16", c_e16, 32);
      chk_int("s3_en_8", c_e8, 32);
      chk_int("s3_en_4", c_e4, 32);
      chk_int("s3_out_last", c_last, 1);

      // 8x8 with a 3-cycle downstream stall mid-block
      run_block(1, 100, 100, 5, -1);
      chk_int("s1_xfers", c_xfer, 8);
      chk_int("s1_in_ready_in_stall", c_stall_inr, 0);
      chk_int("s1_done", c_done, 1);

      // 16x16 with a spurious start at row 5
      run_block(2, 100, 100, -1, 5);
      chk_int("s2_accepts", c_acc, 16);
      chk_int("s2_xfers", c_xfer, 16);
      chk("s2_err", err, ERR_ON);

      // reset during flush of an 8x8 block
      clr_counts();
      start = 1'b1; size = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      start = 1'b0;
      k = 0;
      while (m_mode != 2 && k < 100) begin cycle(); k++; end
      chk_int("flush_reached", m_mode, 2);
      cycle();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rstf_busy", busy, 1'b0);
      chk("rstf_en_8", en_8, 1'b0);
      chk("rstf_en_4", en_4, 1'b0);
      chk("rstf_out_valid", out_valid, 1'b0);
      chk("rstf_in_ready", in_ready, 1'b0);
      chk("rstf_err", err, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) cycle();
      chk_int("rstf_no_done", c_done, 0);
      run_block(1, 100, 100, -1, -1);
      chk_int("after_rst_xfers", c_xfer, 8);
      chk_int("after_rst_done", c_done, 1);

      // randomized blocks with random back-pressure and occasional stray starts
      for (int b = 0; b < 12; b++) begin
         int sz;
         sz = $urandom_range(0, 3);
         run_block(sz, $urandom_range(40, 100), $urandom_range(30, 100), -1,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
         chk_int("rand_xfers", c_xfer, 4 << sz);
         chk_int("rand_done", c_done, 1);
         if ($urandom_range(0, 1) == 1) cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
